// File: rtl/mem_data_memory_hs.sv
// mem_data_memory_hs
//   Byte-addressable, big-endian data memory for the MEM stage with a valid/ready
//   request/response handshake and a programmable access latency. Only one access
//   can be outstanding at a time.
//
//   Parameters
//     ADDR_WIDTH   byte-address decode width; req_addr bits above it must be zero
//     DEPTH_BYTES  storage size in bytes (<= 2**ADDR_WIDTH)
//     LATENCY      cycles from request acceptance to response (1..8)
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     req_valid / req_ready         request handshake (ready only while idle)
//     req_write, req_size           store/load, 00 word / 01 half / 10 byte / 11 illegal
//     req_unsigned                  zero- (1) or sign- (0) extension for half/byte loads
//     req_addr, req_wdata           address of the most-significant byte, store data
//     rsp_valid / rsp_ready         response handshake, response held until accepted
//     rsp_rdata, rsp_error          load result (0 for stores/errors), access rejected
//
//   Configuration macro
//     ALIGN_CHECK_EN  when defined, misaligned half/word accesses are rejected as errors
//
//   Stores commit and loads sample the array at the acceptance edge; the counter only
//   delays the response. rst does not clear the array.
module mem_data_memory_hs #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DEPTH_BYTES = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [7:0]  mem_q [DEPTH_BYTES];

   logic                  accept;
   logic [2:0]            nbytes;
   logic [32:0]           last_byte;
   logic                  size_err, range_err, upper_err, misaligned, req_err;
   logic [ADDR_WIDTH-1:0] idx [4];
   logic [7:0]            rd_byte [4];
   logic [31:0]           load_val;
   logic [31:0]           wdata_al;
   logic [3:0]            wr_en;

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_error = error_q;

   // A request coinciding with reset is not taken, so it cannot write the array.
   assign accept = req_valid && req_ready && !rst;

   // ---------------- request decode ----------------
   always_comb begin
      nbytes = 3'd0;
      case (req_size)
         2'b00:   nbytes = 3'd4;
         2'b01:   nbytes = 3'd2;
         2'b10:   nbytes = 3'd1;
         default: nbytes = 3'd0;
      endcase
   end

   assign last_byte = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
   assign size_err  = (req_size == 2'b11);
   assign range_err = (last_byte >= 33'(DEPTH_BYTES));
   assign upper_err = ((req_addr >> ADDR_WIDTH) != 32'd0);

`ifdef ALIGN_CHECK_EN
   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b00) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign req_err = size_err || range_err || upper_err || misaligned;

   // Byte lane i addresses a+i; lane 0 is the most-significant byte.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         idx[i]     = req_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
         rd_byte[i] = mem_q[idx[i]];
      end
   end

   always_comb begin
      load_val = 32'd0;
      case (req_size)
         2'b00: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
         2'b01: load_val = {{16{!req_unsigned && rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
         2'b10: load_val = {{24{!req_unsigned && rd_byte[0][7]}}, rd_byte[0]};
         default: load_val = 32'd0;
      endcase
   end

   // Left-justify the low 8*nbytes store bits so lane i always takes bits [31-8i -: 8].
   assign wdata_al = req_wdata << {3'd4 - nbytes, 3'b000};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         wr_en[i] = accept && req_write && !req_err && (3'(i) < nbytes);
      end
   end

   // Storage is deliberately outside reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            mem_q[idx[i]] <= wdata_al[8*(3-i) +: 8];
         end
      end
   end

   // ---------------- handshake FSM ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               error_d = req_err;
               rdata_d = (req_write || req_err) ? 32'd0 : load_val;
               if (LATENCY <= 1) begin
                  state_d = StResp;
               end else begin
                  cnt_d   = 4'(LATENCY - 1);
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_mem_data_memory_hs.sv
// tb_mem_data_memory_hs
//   Directed bench for mem_data_memory_hs (LATENCY = 2). Drives requests from idle,
//   checks response timing, data, error flag and the handshake, including a held
//   response, reset during an access, and the misaligned-access behaviour for the
//   current ALIGN_CHECK_EN setting.
module tb_mem_data_memory_hs;

   localparam int unsigned AW  = 12;
   localparam int unsigned DB  = 4096;
   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_data_memory_hs #(
      .ADDR_WIDTH  (AW),
      .DEPTH_BYTES (DB),
      .LATENCY     (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_error    (rsp_error)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
   endtask

   // Called #1 after an edge with the DUT idle. After the acceptance edge the request
   // fields are scrambled, since they must only be sampled at acceptance.
   task automatic access(input string tag, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
      check_eq({tag, "/req_ready"}, req_ready, 1);
      drive_req(wr, size, uns, addr, wdata);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_size  = ~size;
      check_eq({tag, "/wait_novalid"}, rsp_valid, 0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      check_eq({tag, "/valid"}, rsp_valid, 1);
      check_eq({tag, "/rdata"}, rsp_rdata, exp_rdata);
      check_eq({tag, "/error"}, rsp_error, exp_err);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "/hold_valid"}, rsp_valid, 1);
         check_eq({tag, "/hold_rdata"}, rsp_rdata, exp_rdata);
         check_eq({tag, "/hold_error"}, rsp_error, exp_err);
         check_eq({tag, "/hold_noready"}, req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq({tag, "/done_ready"}, req_ready, 1);
      check_eq({tag, "/done_novalid"}, rsp_valid, 0);
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      rsp_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check_eq("reset/req_ready", req_ready, 1);
      check_eq("reset/rsp_valid", rsp_valid, 0);
      check_eq("reset/rsp_rdata", rsp_rdata, 0);
      check_eq("reset/rsp_error", rsp_error, 0);

      // Word store/load round trip
      access("st_w_10", 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
      access("ld_w_10", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

      // Extension
      access("ld_h_s", 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFDEAD, 0, 0);
      access("ld_h_u", 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000DEAD, 0, 0);
      access("ld_b_s", 0, 2'b10, 0, 32'h13, 32'h0, 32'hFFFFFFEF, 0, 0);
      access("ld_b_u", 0, 2'b10, 1, 32'h13, 32'h0, 32'h000000EF, 0, 0);
      access("ld_w_u", 0, 2'b00, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

      // Narrow stores use only the low bits of req_wdata
      access("st_b_11", 1, 2'b10, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, 0);
      access("ld_w_b", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 0);
      access("st_h_20", 1, 2'b01, 0, 32'h20, 32'hFFFF1234, 32'h0, 0, 0);
      access("ld_w_h", 0, 2'b00, 0, 32'h20, 32'h0, 32'h12340000, 0, 0);

      // Errors
      access("err_range", 0, 2'b00, 0, DB - 2, 32'h0, 32'h0, 1, 0);
      access("ld_b_last", 0, 2'b10, 0, DB - 1, 32'h0, 32'h0, 0, 0);
      access("err_size", 1, 2'b11, 0, 32'h10, 32'h11111111, 32'h0, 1, 0);
      access("ld_after_sz", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 0);
      access("err_upper", 1, 2'b00, 0, 32'h1000, 32'hA5A5A5A5, 32'h0, 1, 0);
      access("ld_no_wrap", 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Response held off for 5 cycles
      access("hold5", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 5);

      // rsp_ready high outside RESP must not shorten the access
      rsp_ready = 1'b1;
      drive_req(0, 2'b00, 0, 32'h10, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq("early_rdy/wait", rsp_valid, 0);
      @(posedge clk); #1;
      check_eq("early_rdy/valid", rsp_valid, 1);
      check_eq("early_rdy/rdata", rsp_rdata, 32'hDE55BEEF);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq("early_rdy/idle", req_ready, 1);

      // Reset during WAIT drops the response
      drive_req(0, 2'b00, 0, 32'h10, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      check_eq("rst_wait/in_wait", req_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("rst_wait/novalid", rsp_valid, 0);
      check_eq("rst_wait/ready", req_ready, 1);
      @(posedge clk); #1;
      check_eq("rst_wait/still_novalid", rsp_valid, 0);

      // A store interrupted by reset stays committed
      drive_req(1, 2'b00, 0, 32'h30, 32'hCAFEF00D);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("rst_st/novalid", rsp_valid, 0);
      access("rst_st_ld", 0, 2'b00, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, 0);

      // Misaligned accesses
`ifdef ALIGN_CHECK_EN
      access("mis_w_12", 0, 2'b00, 0, 32'h12, 32'h0, 32'h0, 1, 0);
      access("mis_h_11", 0, 2'b01, 1, 32'h11, 32'h0, 32'h0, 1, 0);
      access("mis_st_h", 1, 2'b01, 0, 32'h13, 32'h7777, 32'h0, 1, 0);
      access("mis_ld_chk", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, 0);
`else
      access("mis_w_12", 0, 2'b00, 0, 32'h12, 32'h0, 32'hBEEF0000, 0, 0);
      access("mis_h_11", 0, 2'b01, 1, 32'h11, 32'h0, 32'h000055BE, 0, 0);
      access("mis_st_h", 1, 2'b01, 0, 32'h13, 32'h7777, 32'h0, 0, 0);
      access("mis_ld_chk", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDE55BE77, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
